spi_receiver: RTL and testbench
===============================

// Module: spi_receiver
// PURPOSE
//   SPI slave-side deserialiser: the stage downstream of the SPI master transmitter on the same board clock.
//   Samples spi_cs_l / spi_sclk / spi_data, shifts DATA_W bits MSB-first on each sclk rising edge,
//   presents completed words on a valid/ready output with overrun and framing-error flags.
// PARAMETERS
//   DATA_W     16   bits per frame (>=2)
// PORTS
//   clk          in   1                 system clock; all logic on posedge clk
//   reset        in   1                 synchronous, active-low reset (0 = reset, sampled on posedge clk)
//   spi_cs_l     in   1                 SPI chip select, active low
//   spi_sclk     in   1                 SPI bus clock (oversampled by clk, >=2 clk per sclk half-period)
//   spi_data     in   1                 SPI serial data (master out)
//   rx_data      out  DATA_W            last completed word
//   rx_valid     out  1                 rx_data holds an unconsumed word
//   rx_ready     in   1                 consumer accepts rx_data when rx_valid && rx_ready
//   rx_overrun   out  1                 1-cycle pulse: word completed while previous still pending; new word dropped
//   frame_err    out  1                 1-cycle pulse: cs_l deasserted with 1..DATA_W-1 bits received
//   bit_count    out  $clog2(DATA_W)+1  bits received in current frame (debug, mirrors tx counter output)
// BEHAVIOUR
//   Reset (reset==0 at posedge): rx_data=0, rx_valid=0, rx_overrun=0, frame_err=0, bit_count=0,
//     shift reg=0, sclk_prev=0, state=IDLE. Reset mid-frame discards partial word, no frame_err.
//   Edge detect: sclk_rise = sclk_s & ~sclk_prev (sclk_s = sampled sclk, see CONFIGURATION).
//   FSM:
//     IDLE   : cs_s==0 -> SHIFT, bit_count=0. sclk edges ignored while cs_s==1.
//     SHIFT  : on sclk_rise: shreg <= {shreg[DATA_W-2:0], data_s}; bit_count++.
//              on sclk_rise with bit_count==DATA_W-1 -> word complete (below), bit_count=DATA_W, -> WAIT_CS.
//              cs_s==1 (no rise same cycle): frame_err=1 iff bit_count!=0; bit_count=0; -> IDLE.
//              cs_s==1 and sclk_rise same cycle: cs wins, edge ignored.
//     WAIT_CS: further sclk edges ignored; cs_s==1 -> IDLE, bit_count=0, no frame_err.
//   Word complete: if !rx_valid or rx_ready: rx_data <= {shreg[DATA_W-2:0],data_s}, rx_valid=1.
//              else: rx_data/rx_valid unchanged, rx_overrun=1 for one cycle.
//   Handshake: rx_valid && rx_ready at posedge clears rx_valid, unless a word completes that cycle (then reloads, stays 1).
//   Latency: rx_valid rises 1 clk after the posedge at which spi_sclk is first seen high for the last bit
//     (3 clk with SPI_RX_SYNC_EN).
//   CS high for a single clk between frames is a legal frame boundary; back-to-back frames lose no bits.
//   bit_count saturates at DATA_W; never wraps.
// CONFIGURATION
//   SPI_RX_SYNC_EN defined  : 2-flop synchronisers on spi_cs_l, spi_sclk, spi_data (+2 clk latency,
//                             identical delay on all three so relative timing is preserved). For async masters.
//   SPI_RX_SYNC_EN undefined: inputs sampled directly (master driven from same clk); cs_s/sclk_s/data_s = raw inputs.
// STRUCTURE
//   Shared include spi_defs.vh: FSM state encodings (IDLE=2'd0, SHIFT=2'd1, WAIT_CS=2'd2), default DATA_W=16.
//   Sub-module spi_sync_edge: optional synchroniser + sclk_prev register + rising-edge output; one instance.
//   Top: FSM, shift register, bit counter, output holding register, flags.
// TESTING
//   1 reset=0 for 2 clk mid-activity -> all outputs 0, state IDLE, bit_count=0.
//   2 frame 16'hA5C3 MSB-first, rx_ready=1 -> rx_valid high 1 clk, rx_data=16'hA5C3, frame_err=0.
//   3 frames 16'h1234 then 16'hFFFF with 1-clk cs gap, rx_ready=0 -> rx_data stays 16'h1234,
//     rx_valid stays 1, rx_overrun pulses exactly once.
//   4 cs_l high after 7 bits -> frame_err 1-clk pulse, rx_valid=0; next frame 16'h0001 received correctly.
//   5 reset asserted after 9 bits of 16'hFFFF -> no frame_err, no rx_valid; next frame 16'h8000 received exactly.
//   6 repeat test 2 with and without SPI_RX_SYNC_EN -> rx_valid latency 3 vs 1 clk after last sclk rise.

Source files
------------

// File: rtl/spi_receiver_pkg.sv
// ----------------------------------------------------------------------------
// spi_receiver_pkg
//   Shared constants for the SPI receiver:
//     - FSM state encodings, legacy-compatible 2-bit constants:
//       IDLE = 2'd0, SHIFT = 2'd1, WAIT_CS = 2'd2.
//     - Default frame width (16 bits).
//   Optional feature macro used by this slice: SPI_RX_SYNC_EN
//   (2-flop input synchronisers, see spi_sync_edge).
// ----------------------------------------------------------------------------
package spi_receiver_pkg;

   localparam int DEFAULT_DATA_W = 16;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SHIFT   = 2'd1;
   localparam logic [1:0] ST_WAIT_CS = 2'd2;

endpackage : spi_receiver_pkg

// File: rtl/spi_sync_edge.sv
// ----------------------------------------------------------------------------
// spi_sync_edge
//   Input conditioning for the SPI receiver: optional 2-flop synchronisers on
//   chip select, serial clock and data, plus the sclk_prev register and the
//   sclk rising-edge detector.
//
//   Macro SPI_RX_SYNC_EN:
//     defined   : each input passes through two flops. All three see the
//                 same delay, so data/clock/cs relative timing is preserved.
//     undefined : the *_s outputs are the raw inputs (master on same clk).
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous active-low reset
//   cs_l_in    in   raw chip select (active low)
//   sclk_in    in   raw SPI clock
//   data_in    in   raw SPI data
//   cs_s       out  conditioned chip select (active low)
//   sclk_s     out  conditioned SPI clock
//   data_s     out  conditioned SPI data
//   sclk_rise  out  sclk_s & ~sclk_prev
// ----------------------------------------------------------------------------
module spi_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic cs_l_in,
   input  logic sclk_in,
   input  logic data_in,
   output logic cs_s,
   output logic sclk_s,
   output logic data_s,
   output logic sclk_rise
);

   logic sclk_prev_q;
   logic sclk_prev_d;

`ifdef SPI_RX_SYNC_EN
   logic [1:0] cs_sync_q,   cs_sync_d;
   logic [1:0] sclk_sync_q, sclk_sync_d;
   logic [1:0] data_sync_q, data_sync_d;

   always_comb begin
      cs_sync_d   = {cs_sync_q[0],   cs_l_in};
      sclk_sync_d = {sclk_sync_q[0], sclk_in};
      data_sync_d = {data_sync_q[0], data_in};
   end

   // Chip select resets to the deselected level so a reset never looks
   // like the start of a frame.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cs_sync_q   <= 2'b11;
         sclk_sync_q <= 2'b00;
         data_sync_q <= 2'b00;
      end else begin
         cs_sync_q   <= cs_sync_d;
         sclk_sync_q <= sclk_sync_d;
         data_sync_q <= data_sync_d;
      end
   end

   assign cs_s   = cs_sync_q[1];
   assign sclk_s = sclk_sync_q[1];
   assign data_s = data_sync_q[1];
`else
   assign cs_s   = cs_l_in;
   assign sclk_s = sclk_in;
   assign data_s = data_in;
`endif

   always_comb begin
      sclk_prev_d = sclk_s;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_prev_q <= sclk_prev_d;
      end
   end

   assign sclk_rise = sclk_s & ~sclk_prev_q;

endmodule : spi_sync_edge

// File: rtl/spi_receiver.sv
// ----------------------------------------------------------------------------
// spi_receiver
//   SPI slave-side deserialiser. Shifts DATA_W bits MSB-first on each rising
//   edge of the (oversampled) SPI clock while chip select is low, and hands
//   completed words to a consumer over a valid/ready interface.
//
//   Handshake: rx_data is transferred on any posedge where rx_valid and
//   rx_ready are both 1. rx_valid stays high and rx_data stays stable until
//   that transfer. A word completing while a previous one is still pending
//   is dropped and flagged with a one-cycle rx_overrun pulse.
//
//   Optional macro SPI_RX_SYNC_EN adds 2-flop input synchronisers
//   (+2 clk latency), see spi_sync_edge.
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous active-low reset
//   spi_cs_l    in   SPI chip select, active low
//   spi_sclk    in   SPI clock (>= 2 clk per half period)
//   spi_data    in   SPI serial data
//   rx_data     out  last completed word
//   rx_valid    out  rx_data holds an unconsumed word
//   rx_ready    in   consumer accepts rx_data
//   rx_overrun  out  1-cycle pulse: completed word dropped
//   frame_err   out  1-cycle pulse: cs released mid-word
//   bit_count   out  bits received in current frame (saturates at DATA_W)
//   fsm_state   out  debug view of the FSM state (ST_* encodings)
// ----------------------------------------------------------------------------
module spi_receiver
   import spi_receiver_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      spi_cs_l,
   input  logic                      spi_sclk,
   input  logic                      spi_data,
   output logic [DATA_W-1:0]         rx_data,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   output logic                      rx_overrun,
   output logic                      frame_err,
   output logic [$clog2(DATA_W):0]   bit_count,
   output logic [1:0]                fsm_state
);

   localparam int CW = $clog2(DATA_W) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DATA_W);

   logic cs_s;
   logic sclk_s;
   logic data_s;
   logic sclk_rise;

   logic [1:0]        state_q,      state_d;
   logic [CW-1:0]     bit_count_q,  bit_count_d;
   logic [DATA_W-1:0] shreg_q,      shreg_d;
   logic [DATA_W-1:0] rx_data_q,    rx_data_d;
   logic              rx_valid_q,   rx_valid_d;
   logic              rx_overrun_q, rx_overrun_d;
   logic              frame_err_q,  frame_err_d;

   logic [DATA_W-1:0] shreg_next;

   spi_sync_edge u_sync_edge (
      .clk       (clk),
      .reset     (reset),
      .cs_l_in   (spi_cs_l),
      .sclk_in   (spi_sclk),
      .data_in   (spi_data),
      .cs_s      (cs_s),
      .sclk_s    (sclk_s),
      .data_s    (data_s),
      .sclk_rise (sclk_rise)
   );

   // sclk_s is only consumed through sclk_rise; kept as a named net for
   // debug visibility.
   logic sclk_s_unused;
   assign sclk_s_unused = sclk_s;

   assign shreg_next = {shreg_q[DATA_W-2:0], data_s};

   always_comb begin
      state_d      = state_q;
      bit_count_d  = bit_count_q;
      shreg_d      = shreg_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q;
      rx_overrun_d = 1'b0;
      frame_err_d  = 1'b0;

      // Consumer handshake; a word completing this same cycle overrides
      // below and keeps rx_valid high with the new data.
      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (!cs_s) begin
               state_d     = ST_SHIFT;
               bit_count_d = '0;
            end
         end

         ST_SHIFT: begin
            // Chip select release takes priority over a coincident edge.
            if (cs_s) begin
               frame_err_d = (bit_count_q != '0);
               bit_count_d = '0;
               state_d     = ST_IDLE;
            end else if (sclk_rise) begin
               shreg_d = shreg_next;
               if (bit_count_q == LAST_BIT) begin
                  bit_count_d = FULL_CNT;
                  state_d     = ST_WAIT_CS;
                  if (!rx_valid_q || rx_ready) begin
                     rx_data_d  = shreg_next;
                     rx_valid_d = 1'b1;
                  end else begin
                     rx_overrun_d = 1'b1;
                  end
               end else begin
                  bit_count_d = bit_count_q + CW'(1);
               end
            end
         end

         ST_WAIT_CS: begin
            if (cs_s) begin
               bit_count_d = '0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            bit_count_d = '0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         bit_count_q  <= '0;
         shreg_q      <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_count_q  <= bit_count_d;
         shreg_q      <= shreg_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         rx_overrun_q <= rx_overrun_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign rx_overrun = rx_overrun_q;
   assign frame_err  = frame_err_q;
   assign bit_count  = bit_count_q;
   assign fsm_state  = state_q;

endmodule : spi_receiver

// File: tb/tb_spi_receiver.sv
// ----------------------------------------------------------------------------
// tb_spi_receiver
//   Self-checking bench for spi_receiver (DATA_W = 16). Expected words are
//   queued when a frame is driven and compared when the DUT hands a word
//   over. Latency expectation follows SPI_RX_SYNC_EN.
// ----------------------------------------------------------------------------
module tb_spi_receiver;

   localparam int DATA_W = 16;
`ifdef SPI_RX_SYNC_EN
   localparam int EXP_LAT = 3;
`else
   localparam int EXP_LAT = 1;
`endif

   logic              clk;
   logic              reset;
   logic              spi_cs_l;
   logic              spi_sclk;
   logic              spi_data;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              rx_overrun;
   logic              frame_err;
   logic [4:0]        bit_count;
   logic [1:0]        fsm_state;

   logic [DATA_W-1:0] exp_q[$];

   int checks;
   int errors;
   int cyc;
   int rise_cyc;
   int lat_meas;
   int valid_hi_cnt;
   int ovr_cnt;
   int ferr_cnt;
   logic valid_prev;

   spi_receiver #(.DATA_W(DATA_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .spi_cs_l   (spi_cs_l),
      .spi_sclk   (spi_sclk),
      .spi_data   (spi_data),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .rx_overrun (rx_overrun),
      .frame_err  (frame_err),
      .bit_count  (bit_count),
      .fsm_state  (fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] w, input int nbits, input bit raise_cs);
      spi_cs_l = 1'b0;
      spi_sclk = 1'b0;
      tick(2);
      for (int i = 0; i < nbits; i++) begin
         spi_data = w[DATA_W-1-i];
         tick(2);
         spi_sclk = 1'b1;
         rise_cyc = cyc;
         tick(2);
         spi_sclk = 1'b0;
      end
      if (raise_cs) begin
         spi_cs_l = 1'b1;
         tick(1);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial valid_prev = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         if (rx_valid && !valid_prev) lat_meas = cyc - rise_cyc;
         if (rx_valid) valid_hi_cnt++;
         if (rx_overrun) ovr_cnt++;
         if (frame_err) ferr_cnt++;
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_word", 32'(exp_q.size()), 32'd1);
            end else begin
               check_eq("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
         end
      end
      valid_prev = rx_valid;
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [DATA_W-1:0] w;
      int ferr_before;

      checks = 0; errors = 0; rise_cyc = 0; lat_meas = 0;
      valid_hi_cnt = 0; ovr_cnt = 0; ferr_cnt = 0;
      reset = 1'b0; spi_cs_l = 1'b1; spi_sclk = 1'b0; spi_data = 1'b0; rx_ready = 1'b1;
      tick(3);
      reset = 1'b1;
      tick(3);

      // Test 1: full frame, then reset in the middle of a second frame.
      exp_q.push_back(16'h5A5A);
      send_frame(16'h5A5A, 16, 1);
      tick(4);
      send_frame(16'hFFFF, 5, 0);
      reset = 1'b0; spi_cs_l = 1'b1;
      tick(2);
      check_eq("rst_rx_data",   32'(rx_data),    32'd0);
      check_eq("rst_rx_valid",  32'(rx_valid),   32'd0);
      check_eq("rst_overrun",   32'(rx_overrun), 32'd0);
      check_eq("rst_frame_err", 32'(frame_err),  32'd0);
      check_eq("rst_bit_count", 32'(bit_count),  32'd0);
      check_eq("rst_state",     32'(fsm_state),  32'd0);
      reset = 1'b1;
      tick(3);

      // Test 2: A5C3 with ready high; one-cycle valid, latency, no frame error.
      valid_hi_cnt = 0;
      ferr_before = ferr_cnt;
      exp_q.push_back(16'hA5C3);
      send_frame(16'hA5C3, 16, 1);
      tick(5);
      check_eq("t2_valid_cycles", 32'(valid_hi_cnt), 32'd1);
      check_eq("t2_latency",      32'(lat_meas),     32'(EXP_LAT));
      check_eq("t2_frame_err",    32'(ferr_cnt - ferr_before), 32'd0);

      // Test 3: two back-to-back frames with consumer stalled -> overrun.
      rx_ready = 1'b0;
      ovr_cnt = 0;
      send_frame(16'h1234, 16, 1);
      send_frame(16'hFFFF, 16, 1);
      tick(5);
      check_eq("t3_rx_data",  32'(rx_data),  32'h1234);
      check_eq("t3_rx_valid", 32'(rx_valid), 32'd1);
      check_eq("t3_overrun",  32'(ovr_cnt),  32'd1);
      exp_q.push_back(16'h1234);
      rx_ready = 1'b1;
      tick(2);
      check_eq("t3_drained", 32'(rx_valid), 32'd0);

      // Test 4: cs released after 7 bits -> frame error; then 0001.
      ferr_before = ferr_cnt;
      send_frame(16'hFE00, 7, 1);
      tick(4);
      check_eq("t4_frame_err", 32'(ferr_cnt - ferr_before), 32'd1);
      check_eq("t4_rx_valid",  32'(rx_valid), 32'd0);
      exp_q.push_back(16'h0001);
      send_frame(16'h0001, 16, 1);
      tick(5);

      // Test 5: reset after 9 bits -> no frame error, no word; then 8000.
      ferr_before = ferr_cnt;
      send_frame(16'hFFFF, 9, 0);
      reset = 1'b0; spi_cs_l = 1'b1; spi_sclk = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(3);
      check_eq("t5_frame_err", 32'(ferr_cnt - ferr_before), 32'd0);
      check_eq("t5_rx_valid",  32'(rx_valid),  32'd0);
      check_eq("t5_bit_count", 32'(bit_count), 32'd0);
      exp_q.push_back(16'h8000);
      send_frame(16'h8000, 16, 1);
      tick(5);

      // Random frames, cs held after the last bit: counter saturates and
      // extra sclk edges are ignored.
      for (int k = 0; k < 4; k++) begin
         w = DATA_W'($urandom_range(0, 65535));
         exp_q.push_back(w);
         ferr_before = ferr_cnt;
         send_frame(w, 16, 0);
         tick(3);
         check_eq("sat_bit_count", 32'(bit_count), 32'd16);
         check_eq("wait_cs_state", 32'(fsm_state), 32'd2);
         spi_sclk = 1'b1; tick(2); spi_sclk = 1'b0; tick(3);
         check_eq("extra_edge_cnt", 32'(bit_count), 32'd16);
         spi_cs_l = 1'b1;
         tick(4);
         check_eq("idle_state",  32'(fsm_state), 32'd0);
         check_eq("idle_count",  32'(bit_count), 32'd0);
         check_eq("no_frame_err", 32'(ferr_cnt - ferr_before), 32'd0);
      end

      tick(4);
      check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_spi_receiver
